// File: rtl/pipereg_elastic.sv
// pipereg_elastic
//   Elastic pipeline register for a stage boundary. Carries a control bundle
//   and a data bundle across a valid/ready handshake. It uses a two-entry skid
//   buffer (main + skid), so in_ready comes only from registered state and
//   never combinationally from out_ready. Flush drops everything held and
//   inserts a bubble. A saturating counter records back-pressure cycles.
// Ports
//   clk, rst          clock; synchronous active-high reset
//   flush             synchronous clear of held entries (in-flight input dropped)
//   in_valid/in_ready upstream handshake; in_ctrl/in_data upstream bundles
//   out_valid/out_ready downstream handshake; out_ctrl/out_data zero when idle
//   stall_cycles      cycles with out_valid && !out_ready (saturating)
module pipereg_elastic #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  stall_cycles
);

    localparam int W = CTRL_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t         state, state_next;
    logic [W-1:0]   main_q, skid_q;
    logic           in_fire, out_fire;
    logic           load_main_in, load_main_skid, load_skid;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst)        state <= EMPTY;
        else if (flush) state <= EMPTY;
        else            state <= state_next;
    end

    // Next state plus entry load enables
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    // Downstream stalled: park the new beat behind main
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Outputs: ready depends only on registered state (and reset)
    always_comb begin
        in_ready  = !rst && (state != FULL);
        out_valid = (state != EMPTY);
        {out_ctrl, out_data} = out_valid ? main_q : '0;
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= {in_ctrl, in_data};
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= {in_ctrl, in_data};
        end
    end

    // Back-pressure counter; flush leaves it alone
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (out_valid && !out_ready && (stall_cycles != {CNT_WIDTH{1'b1}}))
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_pipereg_elastic.sv
module tb_pipereg_elastic;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [NW-1:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    // Reference: a FIFO of at most two beats plus a plain stall count
    logic [CW+DW-1:0] q[$];
    int               m_stall = 0;
    localparam int    SAT = (1 << NW) - 1;

    pipereg_elastic #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model, advance both
    task automatic cyc(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl, input logic r);
        logic             e_ov, e_ir;
        logic [CW+DW-1:0] e_beat;
        rst = r; flush = fl; in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy;
        #1;
        e_ov   = (q.size() > 0);
        e_ir   = !r && (q.size() < 2);
        e_beat = e_ov ? q[0] : '0;
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        chk("in_ready",  64'(in_ready),  64'(e_ir));
        chk("out_ctrl",  64'(out_ctrl),  64'(e_beat[CW+DW-1:DW]));
        chk("out_data",  64'(out_data),  64'(e_beat[DW-1:0]));
        chk("stall",     64'(stall_cycles), 64'(m_stall));
        @(posedge clk);
        if (r) begin
            q.delete();
            m_stall = 0;
        end else begin
            if (e_ov && !ordy && m_stall < SAT) m_stall++;
            if (fl) q.delete();
            else begin
                if (e_ov && ordy) void'(q.pop_front());
                if (v && e_ir) q.push_back({c, d});
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        cyc(0, 8'h00, 32'h0, 0, 0, 1);

        // Stream 1..8 with downstream always ready, then drain with bubbles
        for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 32'(i), 1, 0, 0);
        repeat (3) cyc(0, 8'hFF, 32'hDEAD_BEEF, 1, 0, 0);

        // Back-pressure: accept A, B while stalled, hold, then drain
        cyc(1, 8'h11, 32'hAAAA_0001, 0, 0, 0);
        cyc(1, 8'h22, 32'hBBBB_0002, 0, 0, 0);
        repeat (3) cyc(1, 8'h33, 32'hCCCC_0003, 0, 0, 0);
        repeat (3) cyc(0, 8'h00, 32'h0, 1, 0, 0);

        // Flush while FULL with beat C offered
        cyc(1, 8'h44, 32'h0000_00A1, 0, 0, 0);
        cyc(1, 8'h45, 32'h0000_00B2, 0, 0, 0);
        cyc(1, 8'h46, 32'h0000_00C3, 0, 1, 0);
        repeat (2) cyc(0, 8'h00, 32'h0, 1, 0, 0);

        // Reset mid-operation: FULL with stall count 5
        cyc(0, 8'h00, 32'h0, 0, 1, 1);
        cyc(1, 8'h51, 32'h5151_5151, 0, 0, 0);
        cyc(1, 8'h52, 32'h5252_5252, 0, 0, 0);
        repeat (4) cyc(0, 8'h00, 32'h0, 0, 0, 0);
        chk("stall_five", 64'(stall_cycles), 64'd5);
        repeat (2) cyc(1, 8'h53, 32'h5353_5353, 0, 0, 1);
        cyc(0, 8'h00, 32'h0, 1, 0, 0);

        // Saturation: one beat held for 20 cycles
        cyc(1, 8'h61, 32'h6161_6161, 0, 0, 0);
        repeat (20) cyc(0, 8'h00, 32'h0, 0, 0, 0);
        chk("stall_sat", 64'(stall_cycles), 64'(SAT));
        cyc(0, 8'h00, 32'h0, 1, 0, 0);
        cyc(0, 8'h00, 32'h0, 1, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 10) < 7, 8'($urandom), $urandom,
                ($urandom % 10) < 6, ($urandom % 25) == 0, ($urandom % 150) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
